button_debouncer: RTL and testbench

Conditions the raw push-button input on the TinyFPGA BX board (16 MHz `CLK`) before it reaches the LED control logic. Synchronises the asynchronous pin, rejects contact bounce with a consecutive-sample counter, and produces a clean level, single-cycle press/release/long-press pulses and a toggle state. `LED` consumers use `BTN_LEVEL` for momentary behaviour and `TOGGLE_STATE` for latching behaviour.

---
 rtl/button_debouncer_if.sv | 29 ++
 rtl/button_debouncer.sv | 141 ++++++++++++++
 tb/tb_button_debouncer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
// Button signal bundle between the raw pin source and the debouncer.
// The master drives the raw pin level; the slave returns the conditioned level,
// the press/release/long-press pulses and the toggle state.
interface button_debouncer_if;
    logic BTN_RAW;
    logic BTN_LEVEL;
    logic PRESS_PULSE;
    logic RELEASE_PULSE;
    logic LONG_PULSE;
    logic TOGGLE_STATE;

    modport master (
        output BTN_RAW,
        input  BTN_LEVEL,
        input  PRESS_PULSE,
        input  RELEASE_PULSE,
        input  LONG_PULSE,
        input  TOGGLE_STATE
    );

    modport slave (
        input  BTN_RAW,
        output BTN_LEVEL,
        output PRESS_PULSE,
        output RELEASE_PULSE,
        output LONG_PULSE,
        output TOGGLE_STATE
    );
endinterface

// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, consecutive-sample debounce FSM,
// press/release/long-press single-cycle pulses and a press toggle.
// Latency: accepted change appears DEBOUNCE_CYCLES+1 edges after the raw pin is first sampled; no backpressure.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16000,
    parameter int unsigned LONG_CYCLES     = 16000000
) (
    input  logic               CLK,
    input  logic               RST,
    button_debouncer_if.slave  btn
);

    typedef enum logic [1:0] {
        RELEASED        = 2'd0,
        PRESS_PENDING   = 2'd1,
        PRESSED         = 2'd2,
        RELEASE_PENDING = 2'd3
    } state_t;

    localparam logic [23:0] DEB_LAST  = 24'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0] LONG_LAST = 24'(LONG_CYCLES - 1);

    logic        s1_q, s2_q;
    state_t      state_q;
    logic [23:0] dcnt_q;
    logic [23:0] lcnt_q;
    logic        fired_q;
    logic        level_q, press_q, release_q, long_q, toggle_q;

    logic sync;
    logic rel_accept_d;
    logic in_press_d;

    assign sync = s2_q;

    // Release is accepted on this edge; a coincident long-press condition loses.
    assign rel_accept_d = (state_q == RELEASE_PENDING) && !sync && (dcnt_q == DEB_LAST);
    assign in_press_d   = (state_q == PRESSED) || (state_q == RELEASE_PENDING);

    // Two-stage synchroniser for the asynchronous pin, no logic between stages.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn.BTN_RAW;
            s2_q <= s1_q;
        end
    end

    // Debounce FSM with long-press counter; all outputs registered, pulses self-clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= RELEASED;
            dcnt_q    <= '0;
            lcnt_q    <= '0;
            fired_q   <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;

            case (state_q)
                RELEASED: begin
                    if (sync) begin
                        state_q <= PRESS_PENDING;
                        dcnt_q  <= 24'd1;
                    end else begin
                        dcnt_q  <= '0;
                    end
                end
                PRESS_PENDING: begin
                    if (!sync) begin
                        state_q <= RELEASED;
                        dcnt_q  <= '0;
                    end else if (dcnt_q == DEB_LAST) begin
                        state_q  <= PRESSED;
                        dcnt_q   <= '0;
                        level_q  <= 1'b1;
                        press_q  <= 1'b1;
                        toggle_q <= ~toggle_q;
                        lcnt_q   <= 24'd1;
                        fired_q  <= 1'b0;
                    end else begin
                        dcnt_q <= dcnt_q + 24'd1;
                    end
                end
                PRESSED: begin
                    if (!sync) begin
                        state_q <= RELEASE_PENDING;
                        dcnt_q  <= 24'd1;
                    end else begin
                        dcnt_q  <= '0;
                    end
                end
                RELEASE_PENDING: begin
                    if (sync) begin
                        // Bounce while pressed: level stays high, no pulse.
                        state_q <= PRESSED;
                        dcnt_q  <= '0;
                    end else if (dcnt_q == DEB_LAST) begin
                        state_q   <= RELEASED;
                        dcnt_q    <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                        lcnt_q    <= '0;
                        fired_q   <= 1'b0;
                    end else begin
                        dcnt_q <= dcnt_q + 24'd1;
                    end
                end
                default: begin
                    state_q <= RELEASED;
                    dcnt_q  <= '0;
                end
            endcase

            // Long-press timing runs through release bounces; it saturates once fired.
            if (in_press_d && !rel_accept_d && !fired_q) begin
                if (lcnt_q == LONG_LAST) begin
                    long_q  <= 1'b1;
                    fired_q <= 1'b1;
                end else begin
                    lcnt_q <= lcnt_q + 24'd1;
                end
            end
        end
    end

    assign btn.BTN_LEVEL     = level_q;
    assign btn.PRESS_PULSE   = press_q;
    assign btn.RELEASE_PULSE = release_q;
    assign btn.LONG_PULSE    = long_q;
    assign btn.TOGGLE_STATE  = toggle_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Every cycle the DUT is compared with a run-length reference model; directed
// steps also check pulse timing and counts against hand-derived numbers.
module tb_button_debouncer;

    localparam int N = 4;
    localparam int L = 20;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    button_debouncer_if bif ();

    button_debouncer #(
        .DEBOUNCE_CYCLES(N),
        .LONG_CYCLES    (L)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .btn(bif)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: raw pin delayed two edges, then a run of N samples that
    // disagree with the accepted level flips it. Long press fires L-1 edges
    // after the press edge while the level is still high.
    bit m_s1, m_s2, m_lvl, m_tog, m_press, m_rel, m_long;
    int m_run, m_age;

    // Observed DUT pulse history.
    int cyc;
    int n_press, n_rel, n_long;
    int last_press_cyc, last_long_cyc;
    int high_cycles;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_tog = 0;
        m_press = 0; m_rel = 0; m_long = 0;
        m_run = 0; m_age = 0;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"},   bif.BTN_LEVEL,     1'b0);
        check({tag, "_press"},   bif.PRESS_PULSE,   1'b0);
        check({tag, "_release"}, bif.RELEASE_PULSE, 1'b0);
        check({tag, "_long"},    bif.LONG_PULSE,    1'b0);
        check({tag, "_toggle"},  bif.TOGGLE_STATE,  1'b0);
    endtask

    // One clock with the raw pin at r; model advanced, DUT compared at negedge.
    task automatic step(input bit r);
        bit samp;
        bif.BTN_RAW = r;
        @(posedge CLK);
        cyc++;
        samp = m_s2;
        m_s2 = m_s1;
        m_s1 = r;
        m_press = 0; m_rel = 0; m_long = 0;
        if (samp != m_lvl) m_run++;
        else               m_run = 0;
        if (m_run == N) begin
            m_run = 0;
            m_lvl = samp;
            if (samp) begin
                m_press = 1;
                m_tog   = !m_tog;
                m_age   = 0;
            end else begin
                m_rel = 1;
            end
        end else if (m_lvl) begin
            m_age++;
            if (m_age == L - 1) m_long = 1;
        end
        @(negedge CLK);
        check("level",   bif.BTN_LEVEL,     m_lvl);
        check("press",   bif.PRESS_PULSE,   m_press);
        check("release", bif.RELEASE_PULSE, m_rel);
        check("long",    bif.LONG_PULSE,    m_long);
        check("toggle",  bif.TOGGLE_STATE,  m_tog);
        if (bif.PRESS_PULSE === 1'b1)   begin n_press++; last_press_cyc = cyc; end
        if (bif.RELEASE_PULSE === 1'b1) n_rel++;
        if (bif.LONG_PULSE === 1'b1)    begin n_long++; last_long_cyc = cyc; end
        if (bif.BTN_LEVEL === 1'b1)     high_cycles++;
    endtask

    task automatic hold(input bit r, input int n);
        for (int i = 0; i < n; i++) step(r);
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        int p0, r0, l0, z, seg_len;
        bit tog_before, v;
        bit [6:0] pat;

        cyc = 0; n_press = 0; n_rel = 0; n_long = 0;
        last_press_cyc = -1; last_long_cyc = -1; high_cycles = 0;
        model_reset();

        // Reset with the button held: all outputs stay low.
        bif.BTN_RAW = 1'b1;
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check_all_zero("in_reset");
        end
        RST = 1'b0;
        cyc = 0;

        // Press latency: pin first sampled at edge 1, accepted at edge N+2.
        hold(1'b1, 10);
        check_int("first_press_edge", last_press_cyc, N + 2);
        check_int("first_press_count", n_press, 1);
        check("first_press_toggle", bif.TOGGLE_STATE, 1'b1);

        // Clean release then clean press/release pair with an 8-cycle hold.
        hold(1'b0, 10);
        p0 = n_press; r0 = n_rel; tog_before = bif.TOGGLE_STATE;
        high_cycles = 0;
        hold(1'b1, 8);
        hold(1'b0, 10);
        check_int("pair_press_count", n_press - p0, 1);
        check_int("pair_release_count", n_rel - r0, 1);
        check_int("pair_level_width", high_cycles, 8);
        check("pair_toggle", bif.TOGGLE_STATE, !tog_before);

        // Bounce pattern 1,1,1,0,1,1,0 three times, then held high.
        pat = 7'b1110110;
        p0 = n_press;
        z = 0;
        for (int rep = 0; rep < 3; rep++)
            for (int b = 6; b >= 0; b--) begin
                step(pat[b]);
                if (!pat[b]) z = cyc;
            end
        check_int("bounce_no_press", n_press - p0, 0);
        hold(1'b1, 12);
        check_int("bounce_one_press", n_press - p0, 1);
        check_int("bounce_press_edge", last_press_cyc, z + 2 + N);
        hold(1'b0, 10);

        // Two full presses: toggle flips on each.
        tog_before = bif.TOGGLE_STATE;
        hold(1'b1, 8);
        check("two_press_1_toggle", bif.TOGGLE_STATE, !tog_before);
        hold(1'b0, 8);
        hold(1'b1, 8);
        check("two_press_2_toggle", bif.TOGGLE_STATE, tog_before);
        hold(1'b0, 8);

        // Long press: one LONG_PULSE, L-1 edges after the press.
        l0 = n_long;
        hold(1'b1, 60);
        check_int("long_count", n_long - l0, 1);
        check_int("long_delay", last_long_cyc - last_press_cyc, L - 1);
        hold(1'b0, 10);

        // Short hold: no long pulse.
        l0 = n_long;
        hold(1'b1, 10);
        hold(1'b0, 10);
        check_int("short_no_long", n_long - l0, 0);

        // Release glitch of 3 low cycles while pressed.
        hold(1'b1, 10);
        p0 = n_press; r0 = n_rel;
        hold(1'b0, 3);
        hold(1'b1, 10);
        check_int("glitch_no_release", n_rel - r0, 0);
        check_int("glitch_no_press", n_press - p0, 0);
        check("glitch_level", bif.BTN_LEVEL, 1'b1);

        // Reset mid-press: outputs drop at once, then a fresh press.
        #2 RST = 1'b1;
        #1 check_all_zero("mid_reset");
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        p0 = n_press;
        hold(1'b1, 10);
        check_int("post_reset_press", n_press - p0, 1);
        check("post_reset_toggle", bif.TOGGLE_STATE, 1'b1);
        hold(1'b0, 10);

        // Randomized segments of short bounces and occasional long holds.
        for (int s = 0; s < 300; s++) begin
            v = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) seg_len = $urandom_range(18, 30);
            else                           seg_len = $urandom_range(1, N + 2);
            hold(v, seg_len);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
